// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and defaults for the conv output stream
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } conv_state_e;

    localparam int PAR_OC_DEF = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;

endmodule

// File: rtl/conv_out_stream.sv
// rtl/conv_out_stream.sv - buffers quantizer or maxpool beats into a framed output stream
module conv_out_stream
    import conv_pkg::*;
#(
    parameter int PAR_OC     = PAR_OC_DEF,
    parameter int FIFO_DEPTH = 32,
    parameter int AF_MARGIN  = 4,
    parameter int CNT_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cfg_use_maxpool,
    input  logic [CNT_W-1:0]      cfg_out_pixels,
    input  logic [8*PAR_OC-1:0]   quant_data,
    input  logic                  quant_valid,
    input  logic [8*PAR_OC-1:0]   pool_data,
    input  logic                  pool_valid,
    output logic                  stall,
    output logic [8*PAR_OC-1:0]   m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  extra,
    output logic [CNT_W-1:0]      beat_count
);

    localparam int DW    = 8 * PAR_OC;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] AF_LEVEL = OCC_W'(FIFO_DEPTH - AF_MARGIN);

    conv_state_e      state_q, state_d;
    logic             use_pool_q, use_pool_d;
    logic [CNT_W-1:0] pixels_q, pixels_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             overflow_q, overflow_d;
    logic             extra_q, extra_d;
    logic             stall_q, stall_d;
    logic             done_q, done_d;

    logic             sel_valid;
    logic [DW-1:0]    sel_data;
    logic             fifo_wr, fifo_rd;
    logic             fifo_empty, fifo_full;
    logic [OCC_W-1:0] fifo_count, occ_next;
    logic [DW-1:0]    fifo_rd_data;
    logic             head_is_last;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (sel_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        use_pool_d   = use_pool_q;
        pixels_d     = pixels_q;
        wr_cnt_d     = wr_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        overflow_d   = overflow_q;
        extra_d      = extra_q;
        fifo_wr      = 1'b0;
        fifo_rd      = !fifo_empty && m_ready;
        sel_valid    = use_pool_q ? pool_valid : quant_valid;
        sel_data     = use_pool_q ? pool_data  : quant_data;
        head_is_last = (beat_cnt_q == pixels_q - 1'b1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    use_pool_d = cfg_use_maxpool;
                    pixels_d   = cfg_out_pixels;
                    wr_cnt_d   = '0;
                    beat_cnt_d = '0;
                    overflow_d = 1'b0;
                    extra_d    = 1'b0;
                    state_d    = (cfg_out_pixels == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Writes are capped at the configured beat count so the FIFO
                // drains to empty exactly when the last beat leaves.
                if (sel_valid) begin
                    if (wr_cnt_q >= pixels_q) begin
                        extra_d = 1'b1;
                    end else if (!fifo_full || fifo_rd) begin
                        fifo_wr  = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (fifo_rd) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (head_is_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        occ_next = fifo_count;
        if (fifo_wr && !fifo_rd) begin
            occ_next = fifo_count + 1'b1;
        end else if (!fifo_wr && fifo_rd) begin
            occ_next = fifo_count - 1'b1;
        end
        stall_d = (occ_next >= AF_LEVEL);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            use_pool_q <= 1'b0;
            pixels_q   <= '0;
            wr_cnt_q   <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
            extra_q    <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            use_pool_q <= use_pool_d;
            pixels_q   <= pixels_d;
            wr_cnt_q   <= wr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            overflow_q <= overflow_d;
            extra_q    <= extra_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
        end
    end

    assign m_data     = fifo_rd_data;
    assign m_valid    = !fifo_empty;
    assign m_last     = (state_q == ST_STREAM) && !fifo_empty && head_is_last;
    assign stall      = stall_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign extra      = extra_q;
    assign beat_count = beat_cnt_q;

endmodule
